// File: rtl/uvma_clk_gate_ctrl.sv
// Clock-gating controller: wakes a shared gated clock on demand, acks requesters
// once stable, and gates it off after an idle hold-off. Optional stats: UVMA_CLK_GATE_CTRL_STATS_EN.
module uvma_clk_gate_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WAKE_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               force_on_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               clk_en_o,
  output logic [1:0]         state_o,
  output logic [31:0]        stat_wake_cnt_o,
  output logic [31:0]        stat_en_cyc_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       any_req;

  assign any_req = (|req_i) | force_on_i;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_OFF: begin
        if (any_req) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = WAKE_LOAD;
        end
      end
      // Wake-up always runs to completion so the clock can settle.
      ST_WAKE: begin
        if (cnt == 8'd0) state_nxt = ST_ON;
        else             cnt_nxt   = cnt - 8'd1;
      end
      ST_ON: begin
        if (!any_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = IDLE_LOAD;
        end
      end
      ST_HOLD: begin
        if (any_req)            state_nxt = ST_ON;
        else if (cnt == 8'd0)   state_nxt = ST_OFF;
        else                    cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_OFF;
      cnt      <= '0;
      clk_en_o <= 1'b0;
      ack_o    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clk_en_o <= (state_nxt != ST_OFF);
      ack_o    <= (state_nxt == ST_ON) ? req_i : '0;
    end
  end

  assign state_o = state;

`ifdef UVMA_CLK_GATE_CTRL_STATS_EN
  logic [31:0] wake_cnt, en_cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      wake_cnt <= '0;
      en_cyc   <= '0;
    end else begin
      if ((state == ST_OFF) && (state_nxt == ST_WAKE) && (wake_cnt != '1))
        wake_cnt <= wake_cnt + 32'd1;
      if (clk_en_o && (en_cyc != '1))
        en_cyc <= en_cyc + 32'd1;
    end
  end

  assign stat_wake_cnt_o = wake_cnt;
  assign stat_en_cyc_o   = en_cyc;
`else
  assign stat_wake_cnt_o = '0;
  assign stat_en_cyc_o   = '0;
`endif

endmodule

// File: tb/tb_uvma_clk_gate_ctrl.sv
// Randomized bench for uvma_clk_gate_ctrl against a timer-based reference model.
module tb_uvma_clk_gate_ctrl;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned WAKE_CYCLES = 4;
  localparam int unsigned IDLE_CYCLES = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req;
  logic               force_on;
  logic [NUM_REQ-1:0] ack;
  logic               clk_en;
  logic [1:0]         state;
  logic [31:0]        stat_wake, stat_en;

  always #5 clk = ~clk;

  uvma_clk_gate_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .WAKE_CYCLES(WAKE_CYCLES),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req),
    .force_on_i     (force_on),
    .ack_o          (ack),
    .clk_en_o       (clk_en),
    .state_o        (state),
    .stat_wake_cnt_o(stat_wake),
    .stat_en_cyc_o  (stat_en)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: power flag, remaining wake cycles, consecutive idle cycles.
  bit                 m_en;
  int unsigned        m_wake_left;
  int unsigned        m_idle_run;
  logic [NUM_REQ-1:0] m_ack;
  int unsigned        m_wakes;
  int unsigned        m_en_cycles;

  task automatic model_edge();
    bit any;
    if (reset) begin
      m_en = 0; m_wake_left = 0; m_idle_run = 0; m_ack = '0;
      m_wakes = 0; m_en_cycles = 0;
    end else begin
      any = (req != '0) || force_on;
      if (m_en) m_en_cycles++;
      if (!m_en) begin
        if (any) begin
          m_en = 1; m_wake_left = WAKE_CYCLES; m_wakes++;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
      end else if (any) begin
        m_idle_run = 0;
      end else begin
        m_idle_run++;
        if (m_idle_run > IDLE_CYCLES) begin
          m_en = 0; m_idle_run = 0;
        end
      end
      m_ack = (m_en && m_wake_left == 0 && m_idle_run == 0) ? req : '0;
    end
  endtask

  function automatic logic [1:0] m_state();
    if (!m_en)            return 2'd0;
    if (m_wake_left > 0)  return 2'd1;
    if (m_idle_run == 0)  return 2'd2;
    return 2'd3;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("state", 32'(state), 32'(m_state()));
    chk("clk_en", 32'(clk_en), 32'(m_en));
    chk("ack", 32'(ack), 32'(m_ack));
`ifdef UVMA_CLK_GATE_CTRL_STATS_EN
    chk("stat_wake", stat_wake, m_wakes);
    chk("stat_en", stat_en, m_en_cycles);
`else
    chk("stat_wake", stat_wake, 32'd0);
    chk("stat_en", stat_en, 32'd0);
`endif
  endtask

  initial begin
    int unsigned mode, len;
    logic [NUM_REQ-1:0] hold_req;
    reset = 1'b1; req = '1; force_on = 1'b0;
    m_en = 0; m_wake_left = 0; m_idle_run = 0; m_ack = '0; m_wakes = 0; m_en_cycles = 0;
    @(negedge clk);
    repeat (3) step();
    reset = 1'b0;
    repeat (8) step();
    req = '0;
    repeat (20) step();

    for (int seg = 0; seg < 80; seg++) begin
      mode     = $urandom_range(0, 3);
      len      = $urandom_range(3, 40);
      hold_req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int c = 0; c < int'(len); c++) begin
        reset = ($urandom_range(0, 199) == 0);
        unique case (mode)
          0: begin req = '0; force_on = 1'b0; end
          1: begin req = NUM_REQ'($urandom); force_on = ($urandom_range(0, 9) == 0); end
          2: begin
               req = ($urandom_range(0, 3) == 0) ? NUM_REQ'(1 << $urandom_range(0, NUM_REQ - 1)) : '0;
               force_on = 1'b0;
             end
          default: begin req = hold_req; force_on = 1'b0; end
        endcase
        step();
      end
    end

    reset = 1'b1; req = '0; force_on = 1'b0;
    step();
    reset = 1'b0;
    force_on = 1'b1;
    repeat (100) step();
    force_on = 1'b0;
    repeat (25) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
